simplez_mem_arbiter: RTL and testbench



---
 rtl/simplez_mem_arbiter.sv | 91 +++++++++
 tb/tb_simplez_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_mem_arbiter.sv
// Shares the Simplez 512x12 synchronous memory between the CPU and a debug/loader port.
// Round-robin per-cycle grants, one-cycle read latency, debug lock taken at an instruction boundary.
module simplez_mem_arbiter #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_idle,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          dbg_lock_req,
    output logic          dbg_lock_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StShared, StDrain, StLocked} state_e;

    state_e state_q, state_d;
    logic   last_dbg_q, last_dbg_d;
    logic   sel_dbg_q, sel_dbg_d;
    logic   rd_cpu_q, rd_dbg_q;
    logic   cpu_elig;

    // A lock request blocks the CPU in the very cycle it appears, so the CPU loses any tie.
    assign cpu_elig = rstn && (state_q == StShared) && !dbg_lock_req;
    assign cpu_gnt  = cpu_elig && cpu_req && (!dbg_req || last_dbg_q);
    assign dbg_gnt  = rstn && dbg_req && !cpu_gnt;

    assign last_dbg_d = dbg_gnt ? 1'b1 : (cpu_gnt ? 1'b0 : last_dbg_q);
    // Select stays on the last winner when idle, so mem_addr holds steady without a grant.
    assign sel_dbg_d  = dbg_gnt ? 1'b1 : (cpu_gnt ? 1'b0 : sel_dbg_q);

    assign mem_addr  = sel_dbg_d ? dbg_addr : cpu_addr;
    assign mem_wdata = sel_dbg_d ? dbg_wdata : cpu_wdata;
    assign mem_we    = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);

    assign cpu_rvalid   = rd_cpu_q;
    assign dbg_rvalid   = rd_dbg_q;
    assign cpu_rdata    = mem_rdata;
    assign dbg_rdata    = mem_rdata;
    assign dbg_lock_ack = (state_q == StLocked);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StShared: if (dbg_lock_req) state_d = StDrain;
            StDrain: begin
                if (!dbg_lock_req) begin
                    state_d = StShared;
                end else if (cpu_idle && !rd_cpu_q) begin
                    state_d = StLocked;
                end
            end
            StLocked: if (!dbg_lock_req) state_d = StShared;
            default:  state_d = StShared;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StShared;
            last_dbg_q <= 1'b1;
            sel_dbg_q  <= 1'b0;
            rd_cpu_q   <= 1'b0;
            rd_dbg_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dbg_q <= last_dbg_d;
            sel_dbg_q  <= sel_dbg_d;
            rd_cpu_q   <= cpu_gnt && !cpu_we;
            rd_dbg_q   <= dbg_gnt && !dbg_we;
        end
    end

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Bench for simplez_mem_arbiter: directed plan steps, then random traffic checked
// against a cycle-level reference model with a shadow copy of the memory.
module tb_simplez_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we, cpu_idle;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_lock_req, dbg_lock_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    simplez_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_idle(cpu_idle), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock_req(dbg_lock_req), .dbg_lock_ack(dbg_lock_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory device driven by the arbiter.
    logic [DW-1:0] mem_dev [512];
    always @(posedge clk) begin
        if (mem_we) mem_dev[mem_addr] <= mem_wdata;
        mem_rdata <= mem_dev[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: arbitration mode, who went last, pending reads, shadow memory.
    int            m_mode = 0;   // 0 shared, 1 draining, 2 locked
    bit            m_known = 0;
    bit            m_last_dbg = 1;
    bit            m_pc = 0, m_pd = 0;
    logic [DW-1:0] m_pcd, m_pdd;
    logic [DW-1:0] shadow [512];
    bit            e_cg, e_dg;
    bit            c_held, d_held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit cpu_can;
        #1;
        e_cg = 0;
        e_dg = 0;
        if (rstn === 1'b1) begin
            cpu_can = (m_mode == 0) && !dbg_lock_req;
            if (cpu_can && cpu_req && dbg_req) begin
                if (m_last_dbg) e_cg = 1; else e_dg = 1;
            end else if (cpu_can && cpu_req) begin
                e_cg = 1;
            end else if (dbg_req) begin
                e_dg = 1;
            end
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
        chk("mem_we", 32'(mem_we), 32'((e_cg && cpu_we) || (e_dg && dbg_we)));
        if (e_cg || e_dg) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_cg ? cpu_addr : dbg_addr));
            if ((e_cg && cpu_we) || (e_dg && dbg_we))
                chk("mem_wdata", 32'(mem_wdata), 32'(e_cg ? cpu_wdata : dbg_wdata));
        end
        if (m_known) begin
            chk("lock_ack", 32'(dbg_lock_ack), 32'(m_mode == 2));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pc));
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pd));
            if (m_pc) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_pcd));
            if (m_pd) chk("dbg_rdata", 32'(dbg_rdata), 32'(m_pdd));
        end
    endtask

    task automatic adv();
        bit old_pc;
        @(posedge clk);
        if (!rstn) begin
            m_mode = 0; m_last_dbg = 1; m_pc = 0; m_pd = 0; m_known = 1;
        end else begin
            old_pc = m_pc;
            m_pc = e_cg && !cpu_we;
            m_pd = e_dg && !dbg_we;
            if (m_pc) m_pcd = shadow[cpu_addr];
            if (m_pd) m_pdd = shadow[dbg_addr];
            if (e_cg && cpu_we) shadow[cpu_addr] = cpu_wdata;
            if (e_dg && dbg_we) shadow[dbg_addr] = dbg_wdata;
            if (e_cg) m_last_dbg = 0;
            if (e_dg) m_last_dbg = 1;
            case (m_mode)
                0: if (dbg_lock_req) m_mode = 1;
                1: if (!dbg_lock_req) m_mode = 0;
                   else if (cpu_idle && !old_pc) m_mode = 2;
                default: if (!dbg_lock_req) m_mode = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        tick();
        adv();
    endtask

    task automatic dbg_rand_read();
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'($urandom_range(0, 511));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_dev[i] = 12'($urandom);
            shadow[i] = mem_dev[i];
        end
        mem_dev[5] = 12'h2A3;
        shadow[5] = 12'h2A3;
        rstn = 0; cpu_idle = 1; dbg_lock_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h001; cpu_wdata = '0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h002; dbg_wdata = '0;
        @(negedge clk);

        // Reset with both requesting, then alternation starting with the CPU.
        for (int i = 0; i < 3; i++) cyc();
        rstn = 1;
        tick(); chk("first_tie_cpu", 32'(cpu_gnt), 32'd1); adv();
        tick(); chk("second_tie_dbg", 32'(dbg_gnt), 32'd1); adv();
        for (int i = 0; i < 4; i++) cyc();

        // Plain CPU read of address 5.
        dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
        tick(); chk("rd5_gnt", 32'(cpu_gnt), 32'd1); adv();
        cpu_req = 0;
        tick();
        chk("rd5_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd5_data", 32'(cpu_rdata), 32'h2A3);
        adv();

        // Contended: dbg writes 0x7FF to 0x010 while CPU reads it; last winner was CPU.
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 12'h7FF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tick(); chk("cont_dbg_first", 32'(dbg_gnt), 32'd1); adv();
        dbg_req = 0;
        cyc();
        cpu_req = 0;
        tick(); chk("cont_rd_data", 32'(cpu_rdata), 32'h7FF); adv();

        // Lock while CPU is busy; CPU holds a request that must not be served.
        dbg_lock_req = 1; cpu_idle = 0; cpu_req = 1; cpu_addr = 9'h033;
        for (int i = 0; i < 5; i++) begin
            dbg_rand_read();
            tick(); chk("busy_no_ack", 32'(dbg_lock_ack), 32'd0); adv();
        end
        cpu_idle = 1;
        dbg_rand_read();
        tick(); chk("idle_ack_pending", 32'(dbg_lock_ack), 32'd0); adv();
        dbg_rand_read();
        tick(); chk("ack_up", 32'(dbg_lock_ack), 32'd1); adv();

        // Release: ack drops and the CPU wins the next cycle.
        dbg_lock_req = 0; dbg_req = 0;
        tick(); chk("release_no_cpu", 32'(cpu_gnt), 32'd0); adv();
        tick(); chk("release_cpu", 32'(cpu_gnt), 32'd1); adv();
        cpu_req = 0;

        // Abort during drain.
        dbg_lock_req = 1; cpu_idle = 0;
        cyc(); cyc();
        dbg_lock_req = 0;
        cyc();
        cpu_req = 1;
        tick(); chk("abort_cpu", 32'(cpu_gnt), 32'd1); adv();
        cpu_req = 0;
        cyc();

        // Reset while locked with a dbg read in flight.
        dbg_lock_req = 1; cpu_idle = 1;
        cyc(); cyc();
        dbg_rand_read();
        tick(); chk("lock_rd_ack", 32'(dbg_lock_ack), 32'd1); adv();
        rstn = 0; dbg_req = 0;
        cyc();
        tick();
        chk("rst_ack", 32'(dbg_lock_ack), 32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        adv();
        rstn = 1; dbg_lock_req = 0;

        // Random traffic against the model.
        c_held = 0; d_held = 0; cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rstn = 0; else rstn = 1;
            if ($urandom_range(0, 99) < 4) dbg_lock_req = ~dbg_lock_req;
            cpu_idle = 1'($urandom_range(0, 1));
            if (!c_held) begin
                cpu_req = ($urandom_range(0, 99) < 60);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 9'($urandom_range(0, 31));
                cpu_wdata = 12'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                cpu_req = 0;
            end
            if (!d_held) begin
                dbg_req = ($urandom_range(0, 99) < 50);
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 9'($urandom_range(0, 31));
                dbg_wdata = 12'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                dbg_req = 0;
            end
            tick();
            c_held = cpu_req && !e_cg;
            d_held = dbg_req && !e_dg;
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
